// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment mux driver.
//   seg_t   - active-low segment vector {a,b,c,d,e,f,g}, bit 6 = a
//   SEG_OFF - all segments dark
//   GLYPH   - nibble-to-glyph table, indices 0..15 (0-9, A, b, C, d, E, F)
package ssd_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'b1111111;

  localparam seg_t GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/ssd_glyph_decode.sv
// ssd_glyph_decode: combinational nibble-to-glyph decoder (active-low).
//   HEX_MODE - 1: A..F shown as hex glyphs; 0: values above 9 are blank
//   i_nib    - input nibble
//   o_seg    - segments {a,b,c,d,e,f,g}, active-low
module ssd_glyph_decode
  import ssd_pkg::*;
#(
  parameter int unsigned HEX_MODE = 1
) (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH[i_nib];
    if (HEX_MODE == 0 && i_nib > 4'd9) o_seg = SEG_OFF;
  end

endmodule

// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver: time-multiplexed N-digit common-anode seven-segment driver.
// Digit values are snapshotted once per frame (at the index wrap) and one digit
// is scanned per REFRESH_DIV-cycle slot, with BLANK_CYCLES of anodes-off at the
// start of each slot to prevent ghosting. All outputs are registered.
//   clk, rst_n   - clock, asynchronous active-low reset
//   digits_i     - packed nibbles, digit 0 in [3:0]
//   dp_i         - per-digit decimal point request, active-high
//   enable_i     - scan enable; low = dark display, frozen scan
//   an_o         - anode drives, active-low
//   seg_o        - segments {a..g}, bit 6 = a, active-low
//   dp_o         - decimal point, active-low
//   frame_o      - one-cycle pulse after each snapshot load
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is never blanked, anode timing and dp are unaffected).
module ssd_mux_driver
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned HEX_MODE     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    enable_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_o
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap_d;
  logic [NUM_DIGITS-1:0]   r_snap_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  seg_t                    r_seg;
  logic                    r_dp;
  logic                    r_frame;

  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_lz_sel;
  logic [NUM_DIGITS-1:0]   w_lz;
  seg_t                    w_glyph;
  logic [NUM_DIGITS-1:0]   w_an_d;
  seg_t                    w_seg_d;
  logic                    w_dp_d;

  assign w_wrap = enable_i && (r_pre == PRE_LAST) && (r_idx == IDX_LAST);

  // Prescaler, digit index and once-per-frame snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_idx     <= '0;
      r_snap_d  <= '0;
      r_snap_dp <= '0;
    end else if (enable_i) begin
      if (r_pre == PRE_LAST) begin
        r_pre <= '0;
        if (r_idx == IDX_LAST) begin
          r_idx     <= '0;
          r_snap_d  <= digits_i;
          r_snap_dp <= dp_i;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end
    end
  end

  // Leading-zero mask: a digit is blanked when it and every higher digit are 0.
`ifdef SSD_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    w_lz        = '0;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      higher_zero = higher_zero && (r_snap_d[4*i +: 4] == 4'h0);
      w_lz[i]     = higher_zero;
    end
  end
`else
  assign w_lz = '0;
`endif

  // Current-digit selection from the snapshot.
  always_comb begin
    w_nib    = '0;
    w_dp_sel = 1'b0;
    w_lz_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib    = r_snap_d[4*i +: 4];
        w_dp_sel = r_snap_dp[i];
        w_lz_sel = w_lz[i];
      end
    end
  end

  ssd_glyph_decode #(
    .HEX_MODE(HEX_MODE)
  ) u_decode (
    .i_nib(w_nib),
    .o_seg(w_glyph)
  );

  // Next output values; segments stay valid during the blank window.
  always_comb begin
    w_an_d  = '1;
    w_seg_d = SEG_OFF;
    w_dp_d  = 1'b1;
    if (enable_i) begin
      w_seg_d = w_lz_sel ? SEG_OFF : w_glyph;
      w_dp_d  = ~w_dp_sel;
      if (r_pre >= PRE_BLANK) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (r_idx == IDX_W'(i)) w_an_d[i] = 1'b0;
        end
      end
    end
  end

  // Output registers reset asynchronously so the display goes dark at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an    <= '1;
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an_d;
      r_seg   <= w_seg_d;
      r_dp    <= w_dp_d;
      r_frame <= w_wrap;
    end
  end

  assign an_o    = r_an;
  assign seg_o   = r_seg;
  assign dp_o    = r_dp;
  assign frame_o = r_frame;

endmodule
